// File: rtl/clk_meas_pkg.sv
// Shared types and constants for the clock ratio meter.
package clk_meas_pkg;

  localparam int CNT_W_DEF  = 8;
  localparam int LOCK_N_DEF = 4;

  typedef enum logic [0:0] {
    SEEK = 1'b0,
    RUN  = 1'b1
  } meas_state_e;

  // Number of clkin cycles without a rising edge before a timeout is flagged.
  function automatic int timeout_cycles(input int cnt_w);
    return (32'sd1 << cnt_w) - 32'sd1;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for an asynchronous waveform plus rise/fall detect.
module edge_sync (
  input  logic clkin,
  input  logic rst,
  input  logic sig_in,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic s1_r;
  logic s2_r;
  logic sd_r;

  // Synchronise sig_in (s1, s2) and keep one delayed copy (sd) for edges.
  always_ff @(posedge clkin) begin
    if (rst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      sd_r <= 1'b0;
    end else begin
      s1_r <= sig_in;
      s2_r <= s1_r;
      sd_r <= s2_r;
    end
  end

  assign lvl  = s2_r;
  assign rise = s2_r & ~sd_r;
  assign fall = ~s2_r & sd_r;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures period and high time of a divided clock in clkin cycles, with
// lock detection, duty-cycle check and a sticky no-edge timeout.
module clk_ratio_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int LOCK_N = LOCK_N_DEF
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             clr_err,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             duty_ok,
  output logic             timeout
);

  localparam int               MATCH_W  = (LOCK_N > 1) ? $clog2(LOCK_N) : 1;
  localparam logic [MATCH_W-1:0] LOCK_MAX = MATCH_W'(LOCK_N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(timeout_cycles(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic lvl_s;
  logic rise_s;
  logic fall_s;
  logic hi_inc_s;

  meas_state_e        state_r,     state_s;
  logic [CNT_W-1:0]   per_cnt_r,   per_cnt_s;
  logic [CNT_W-1:0]   hi_cnt_r,    hi_cnt_s;
  logic [MATCH_W-1:0] match_cnt_r, match_cnt_s;
  logic [CNT_W-1:0]   period_r,    period_s;
  logic [CNT_W-1:0]   high_time_r, high_time_s;
  logic               valid_r,     valid_s;
  logic               locked_r,    locked_s;
  logic               timeout_r,   timeout_s;

  edge_sync u_edge_sync (
    .clkin  (clkin),
    .rst    (rst),
    .sig_in (sig_in),
    .lvl    (lvl_s),
    .rise   (rise_s),
    .fall   (fall_s)
  );

  // A falling-edge cycle is already low; excluding it keeps the intent explicit.
  assign hi_inc_s = lvl_s & ~fall_s;

  // |2*h - p| <= 1 evaluated one bit wider than the counters; never ok for p = 0.
  function automatic logic duty_check(input logic [CNT_W-1:0] p,
                                      input logic [CNT_W-1:0] h);
    logic [CNT_W:0] twice_h;
    logic [CNT_W:0] p_ext;
    logic [CNT_W:0] diff;
    twice_h = {h, 1'b0};
    p_ext   = {1'b0, p};
    if (twice_h >= p_ext) begin
      diff = twice_h - p_ext;
    end else begin
      diff = p_ext - twice_h;
    end
    return (p != {CNT_W{1'b0}}) && (diff <= {{CNT_W{1'b0}}, 1'b1});
  endfunction

  // Next-state logic for the measurement FSM, counters and flags.
  always_comb begin
    state_s     = state_r;
    per_cnt_s   = per_cnt_r;
    hi_cnt_s    = hi_cnt_r;
    match_cnt_s = match_cnt_r;
    period_s    = period_r;
    high_time_s = high_time_r;
    valid_s     = 1'b0;
    locked_s    = locked_r;
    if (clr_err) begin
      timeout_s = 1'b0;
    end else begin
      timeout_s = timeout_r;
    end

    case (state_r)
      SEEK: begin
        if (rise_s) begin
          state_s   = RUN;
          per_cnt_s = CNT_ONE;
          hi_cnt_s  = CNT_ONE;
        end else begin
          state_s   = SEEK;
        end
      end
      RUN: begin
        if (rise_s) begin
          period_s    = per_cnt_r;
          high_time_s = hi_cnt_r;
          valid_s     = 1'b1;
          per_cnt_s   = CNT_ONE;
          hi_cnt_s    = CNT_ONE;
          if (per_cnt_r == period_r) begin
            if (match_cnt_r == LOCK_MAX) begin
              match_cnt_s = LOCK_MAX;
            end else begin
              match_cnt_s = match_cnt_r + MATCH_W'(1);
            end
          end else begin
            match_cnt_s = {MATCH_W{1'b0}};
          end
          locked_s = (match_cnt_s == LOCK_MAX);
        end else if (per_cnt_r == CNT_MAX) begin
          // No edge for the full counter range: give up and re-acquire.
          timeout_s   = 1'b1;
          locked_s    = 1'b0;
          match_cnt_s = {MATCH_W{1'b0}};
          state_s     = SEEK;
        end else begin
          per_cnt_s = per_cnt_r + CNT_ONE;
          if (hi_inc_s && (hi_cnt_r != CNT_MAX)) begin
            hi_cnt_s = hi_cnt_r + CNT_ONE;
          end else begin
            hi_cnt_s = hi_cnt_r;
          end
        end
      end
      default: begin
        state_s     = SEEK;
        match_cnt_s = {MATCH_W{1'b0}};
        locked_s    = 1'b0;
      end
    endcase
  end

  // State and measurement registers.
  always_ff @(posedge clkin) begin
    if (rst) begin
      state_r     <= SEEK;
      per_cnt_r   <= {CNT_W{1'b0}};
      hi_cnt_r    <= {CNT_W{1'b0}};
      match_cnt_r <= {MATCH_W{1'b0}};
      period_r    <= {CNT_W{1'b0}};
      high_time_r <= {CNT_W{1'b0}};
      valid_r     <= 1'b0;
      locked_r    <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      per_cnt_r   <= per_cnt_s;
      hi_cnt_r    <= hi_cnt_s;
      match_cnt_r <= match_cnt_s;
      period_r    <= period_s;
      high_time_r <= high_time_s;
      valid_r     <= valid_s;
      locked_r    <= locked_s;
      timeout_r   <= timeout_s;
    end
  end

  assign period    = period_r;
  assign high_time = high_time_r;
  assign valid     = valid_r;
  assign locked    = locked_r;
  assign timeout   = timeout_r;
  assign duty_ok   = duty_check(period_r, high_time_r);

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed self-checking bench for clk_ratio_meter (default CNT_W=8, LOCK_N=4).
module tb_clk_ratio_meter;

  logic       clkin;
  logic       rst;
  logic       sig_in;
  logic       clr_err;
  logic [7:0] period;
  logic [7:0] high_time;
  logic       valid;
  logic       locked;
  logic       duty_ok;
  logic       timeout;

  int total;
  int bad;

  int gen_hi;
  int gen_lo;
  logic gen_en;

  clk_ratio_meter #(.CNT_W(8), .LOCK_N(4)) dut (
    .clkin     (clkin),
    .rst       (rst),
    .sig_in    (sig_in),
    .clr_err   (clr_err),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .locked    (locked),
    .duty_ok   (duty_ok),
    .timeout   (timeout)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  // Waveform generator: lengths are latched per period so periods never mix.
  initial begin : gen_blk
    int h;
    int l;
    sig_in = 1'b0;
    forever begin
      if (gen_en === 1'b1) begin
        h = gen_hi;
        l = gen_lo;
        for (int i = 0; i < h; i++) begin
          sig_in = 1'b1;
          @(negedge clkin);
        end
        for (int i = 0; i < l; i++) begin
          sig_in = 1'b0;
          @(negedge clkin);
        end
      end else begin
        sig_in = 1'b0;
        @(negedge clkin);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance clock by clock until valid is seen (sampled 1 time unit after the edge).
  task automatic wait_valid(input int budget, output int n);
    n = 0;
    do begin
      @(posedge clkin);
      #1;
      n++;
    end while (!valid && n < budget);
    if (!valid) check("valid_wait", 32'd0, 32'd1);
  endtask

  initial begin : wdog
    #1000000;
    $display("FAIL watchdog: got=expired expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    int k;
    total   = 0;
    bad     = 0;
    gen_en  = 1'b0;
    gen_hi  = 3;
    gen_lo  = 2;
    rst     = 1'b1;
    clr_err = 1'b0;

    // Reset state
    repeat (3) @(posedge clkin);
    #1;
    check("rst_period",  32'(period),    32'd0);
    check("rst_high",    32'(high_time), 32'd0);
    check("rst_valid",   32'(valid),     32'd0);
    check("rst_locked",  32'(locked),    32'd0);
    check("rst_timeout", 32'(timeout),   32'd0);
    check("rst_duty",    32'(duty_ok),   32'd0);
    @(negedge clkin);
    rst = 1'b0;

    // 3 high / 2 low: period 5, high 3, lock on 4th valid
    gen_hi = 3; gen_lo = 2; gen_en = 1'b1;
    for (int v = 1; v <= 5; v++) begin
      wait_valid(40, n);
      if (v >= 2) check("p5_spacing", 32'(n), 32'd5);
      check("p5_period", 32'(period),    32'd5);
      check("p5_high",   32'(high_time), 32'd3);
      check("p5_duty",   32'(duty_ok),   32'd1);
      check("p5_locked", 32'(locked),    (v >= 4) ? 32'd1 : 32'd0);
    end

    // 4 high / 4 low until locked at period 8
    gen_hi = 4; gen_lo = 4;
    for (int v = 0; v < 7; v++) wait_valid(40, n);
    check("p8_period", 32'(period),    32'd8);
    check("p8_high",   32'(high_time), 32'd4);
    check("p8_duty",   32'(duty_ok),   32'd1);
    check("p8_locked", 32'(locked),    32'd1);

    // Switch to 3 high / 3 low: first differing period drops lock
    gen_hi = 3; gen_lo = 3;
    k = 0;
    do begin
      wait_valid(40, n);
      k++;
    end while (period == 8'd8 && k < 4);
    check("p6_period", 32'(period),    32'd6);
    check("p6_high",   32'(high_time), 32'd3);
    check("p6_locked", 32'(locked),    32'd0);
    check("p6_duty",   32'(duty_ok),   32'd1);

    // 1 high / 4 low: duty far from 50 %
    gen_hi = 1; gen_lo = 4;
    for (int v = 0; v < 3; v++) wait_valid(40, n);
    check("p51_period", 32'(period),    32'd5);
    check("p51_high",   32'(high_time), 32'd1);
    check("p51_duty",   32'(duty_ok),   32'd0);

    // Back to 3/2, then reset during the low phase of a period
    gen_hi = 3; gen_lo = 2;
    for (int v = 0; v < 2; v++) wait_valid(40, n);
    check("pre_rst_high", 32'(high_time), 32'd3);
    @(negedge clkin);
    rst = 1'b1;
    @(posedge clkin);
    #1;
    check("mid_rst_period", 32'(period),    32'd0);
    check("mid_rst_high",   32'(high_time), 32'd0);
    check("mid_rst_valid",  32'(valid),     32'd0);
    check("mid_rst_locked", 32'(locked),    32'd0);
    @(negedge clkin);
    rst = 1'b0;
    wait_valid(40, n);
    check("post_rst_period", 32'(period),    32'd5);
    check("post_rst_high",   32'(high_time), 32'd3);
    check("post_rst_locked", 32'(locked),    32'd0);

    // Relock, then stop the waveform and wait for the timeout
    for (int v = 0; v < 3; v++) wait_valid(40, n);
    check("relock", 32'(locked), 32'd1);
    gen_en = 1'b0;
    k = 0;
    do begin
      @(posedge clkin);
      #1;
      k++;
    end while (!timeout && k < 300);
    check("tmo_cycles", 32'(k),         32'd255);
    check("tmo_flag",   32'(timeout),   32'd1);
    check("tmo_locked", 32'(locked),    32'd0);
    check("tmo_period", 32'(period),    32'd5);
    check("tmo_high",   32'(high_time), 32'd3);
    repeat (10) @(posedge clkin);
    #1;
    check("tmo_sticky", 32'(timeout), 32'd1);
    @(negedge clkin);
    clr_err = 1'b1;
    @(posedge clkin);
    #1;
    check("clr_tmo", 32'(timeout), 32'd0);
    @(negedge clkin);
    clr_err = 1'b0;

    // clr_err on the very cycle a new timeout fires: timeout wins
    gen_en = 1'b1;
    wait_valid(40, n);
    gen_en = 1'b0;
    repeat (254) @(posedge clkin);
    #1;
    check("tmo2_early", 32'(timeout), 32'd0);
    clr_err = 1'b1;
    @(posedge clkin);
    #1;
    check("tmo2_vs_clr", 32'(timeout), 32'd1);
    @(posedge clkin);
    #1;
    check("tmo2_clr", 32'(timeout), 32'd0);
    clr_err = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
